// File: rtl/step_conditioner.sv
// step_conditioner: sync + debounce of the step button into single-cycle step ticks, optional hold-to-repeat (macro STEP_AUTOREPEAT_EN).
// Latency: tick/level rise after edge DB_CYCLES+3 of a stable press; level falls after edge DB_CYCLES+3 of a stable release.
// Backpressure: none; free-running pulse source, the counter must accept a tick in any cycle.
module step_conditioner #(
  parameter int unsigned DB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_tick,
  output logic o_level,
  output logic o_repeating
);

  localparam int unsigned   DW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned   RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   RW      = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    S_RELEASED, S_PRESS_CHK, S_HELD, S_REPEAT, S_RELEASE_CHK
  } state_t;

  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_nxt;
  logic          r_repeating;
`else
  typedef enum logic [1:0] {
    S_RELEASED, S_PRESS_CHK, S_HELD, S_RELEASE_CHK
  } state_t;

  // Repeat parameters have no hardware in this build; keep them referenced.
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY < 2) | (REPEAT_RATE < 2);
`endif

  logic [1:0]    r_sync;
  logic          w_key_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_dcnt;
  logic [DW-1:0] w_dcnt_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic          r_level;
  logic          w_level_nxt;

  assign w_key_s = r_sync[1];

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_key};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_RELEASED;
      r_dcnt      <= '0;
      r_tick      <= 1'b0;
      r_level     <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
      r_rcnt      <= '0;
      r_repeating <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_tick      <= w_tick_nxt;
      r_level     <= w_level_nxt;
`ifdef STEP_AUTOREPEAT_EN
      r_rcnt      <= w_rcnt_nxt;
      r_repeating <= (w_state_nxt == S_REPEAT);
`endif
    end
  end

  // Next-state logic; counters only advance while staying put and restart on any state change.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_tick_nxt  = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
    w_rcnt_nxt  = r_rcnt;
`endif
    case (r_state)
      S_RELEASED: begin
        if (w_key_s) w_state_nxt = S_PRESS_CHK;
      end
      S_PRESS_CHK: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASED;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = S_HELD;
          w_tick_nxt  = 1'b1;
        end else begin
          w_dcnt_nxt  = r_dcnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASE_CHK;
`ifdef STEP_AUTOREPEAT_EN
        end else if (r_rcnt == RD_LAST) begin
          w_state_nxt = S_REPEAT;
          w_tick_nxt  = 1'b1;
        end else begin
          w_rcnt_nxt  = r_rcnt + 1'b1;
`endif
        end
      end
`ifdef STEP_AUTOREPEAT_EN
      S_REPEAT: begin
        if (!w_key_s) begin
          w_state_nxt = S_RELEASE_CHK;
        end else if (r_rcnt == RR_LAST) begin
          w_tick_nxt  = 1'b1;
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + 1'b1;
        end
      end
`endif
      S_RELEASE_CHK: begin
        // A bounce back high returns to HELD silently and restarts the repeat delay.
        if (w_key_s) begin
          w_state_nxt = S_HELD;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = S_RELEASED;
        end else begin
          w_dcnt_nxt  = r_dcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_dcnt_nxt = '0;
`ifdef STEP_AUTOREPEAT_EN
      w_rcnt_nxt = '0;
`endif
    end

    w_level_nxt = (w_state_nxt != S_RELEASED) && (w_state_nxt != S_PRESS_CHK);
  end

  assign o_tick  = r_tick;
  assign o_level = r_level;
`ifdef STEP_AUTOREPEAT_EN
  assign o_repeating = r_repeating;
`else
  assign o_repeating = 1'b0;
`endif

endmodule

// File: tb/tb_step_conditioner.sv
// tb_step_conditioner: directed vectors for step_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Latency: expectations are per rising edge, outputs sampled 1 time unit after the edge.
// Backpressure: none; the bench only drives the key and reset.
module tb_step_conditioner;

  logic clk;
  logic rst_n;
  logic key;
  logic tick;
  logic level;
  logic repeating;

  int n_vec;
  int n_err;

  step_conditioner #(
    .DB_CYCLES   (4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_key      (key),
    .o_tick     (tick),
    .o_level    (level),
    .o_repeating(repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set bits lo..hi of a per-edge expectation mask (bit e = edge e of a phase).
  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  // Hold key at k for n edges, checking all three outputs after every edge.
  task automatic run_phase(input string name, input logic k, input int n,
                           input logic [63:0] tmask, input logic [63:0] lmask,
                           input logic [63:0] rmask);
    for (int e = 1; e <= n; e++) begin
      key = k;
      @(posedge clk);
      #1;
      chk($sformatf("%s tick e%0d", name, e), tick, tmask[e]);
      chk($sformatf("%s level e%0d", name, e), level, lmask[e]);
      chk($sformatf("%s repeating e%0d", name, e), repeating, rmask[e]);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " tick"}, tick, 1'b0);
    chk({name, " level"}, level, 1'b0);
    chk({name, " repeating"}, repeating, 1'b0);
  endtask

`ifdef STEP_AUTOREPEAT_EN
  localparam int HOLD_N = 30;
`else
  localparam int HOLD_N = 50;
`endif

  logic [63:0] t_hold, l_hold, r_hold;
  logic [63:0] t_rel, r_rel;
  logic [63:0] t_re, r_re;
  logic [1:0]  bounce_seq;

  initial begin
    n_vec = 0;
    n_err = 0;
    bounce_seq = 2'b00;

    l_hold = bits(7, HOLD_N);
`ifdef STEP_AUTOREPEAT_EN
    t_hold = bits(7, 7) | bits(17, 17) | bits(20, 20) | bits(23, 23) | bits(26, 26) | bits(29, 29);
    r_hold = bits(17, HOLD_N);
    // Key still in the synchroniser at release edges 1-2: rate counter hits its last value at edge 2.
    t_rel  = bits(2, 2);
    r_rel  = bits(1, 2);
    // After the glitch, HELD re-entered at edge 3; repeat ticks at 13 and 16.
    t_re   = bits(13, 13) | bits(16, 16);
    r_re   = bits(13, 16);
`else
    t_hold = bits(7, 7);
    r_hold = '0;
    t_rel  = '0;
    r_rel  = '0;
    t_re   = '0;
    r_re   = '0;
`endif

    // Reset asserted with key high: outputs low before any edge and while held.
    rst_n = 1'b0;
    key   = 1'b1;
    #2;
    chk_zero("reset pre-edge");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;

    // Press held from reset release; first tick after edge 7.
    run_phase("press", 1'b1, HOLD_N, t_hold, l_hold, r_hold);

    // Release: level falls after edge 7, no release tick.
    run_phase("release", 1'b0, 10, t_rel, bits(1, 6), r_rel);

    // Bounce 1,1,1,0 x20: never accepted.
    for (int i = 0; i < 80; i++) begin
      key = (bounce_seq != 2'b11);
      bounce_seq = bounce_seq + 2'b01;
      @(posedge clk);
      #1;
      chk($sformatf("bounce tick e%0d", i + 1), tick, 1'b0);
      chk($sformatf("bounce level e%0d", i + 1), level, 1'b0);
    end
    run_phase("settle", 1'b0, 4, '0, '0, '0);

    // Fresh press, then a 2-cycle low glitch while held.
    run_phase("press2", 1'b1, 12, bits(7, 7), bits(7, 12), '0);
    run_phase("glitch", 1'b0, 2, '0, bits(1, 2), '0);
    run_phase("reheld", 1'b1, 16, t_re, bits(1, 16), r_re);

    // Async reset between edges (in REPEAT with tick high when auto-repeat is built).
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("async reset held");
    @(negedge clk);
    rst_n = 1'b1;
    run_phase("restart", 1'b1, HOLD_N, t_hold, l_hold, r_hold);
    run_phase("release2", 1'b0, 10, t_rel, bits(1, 6), r_rel);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/step_conditioner.md
# step_conditioner

Conditions the raw step pushbutton into clean single-cycle count pulses for the up/down counter, with optional hold-to-repeat. Sits between the board button pin and the counter's tick input, clocked by the system clock and reset by the synchronised reset. Replaces the separate debounce/edge-detect pair on that path and adds auto-repeat, so a held button steps the count continuously.

## Interface
- `DB_CYCLES`, default 1_000_000: clock cycles `key_s` must stay stable to accept a press or release; minimum 2.
- `REPEAT_DELAY`, default 50_000_000: cycles from the first tick to the first repeat tick; minimum 2.
- `REPEAT_RATE`, default 10_000_000: cycles between subsequent repeat ticks; minimum 2.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `key` input, 1 bit: raw, asynchronous, bouncing button, active-high.
- `tick` output, 1 bit: one-cycle, registered step pulse.
- `level` output, 1 bit: registered debounced button state.
- `repeating` output, 1 bit: high while in REPEAT.

## Operation
- **Synchroniser:** 2-FF chain `key` -> `key_s`.
- **Counters:** debounce counter `dcnt` and repeat counter `rcnt`.
  - Each is sized `$clog2` of its largest parameter.
  - Both saturate-free; they are cleared on every state entry.
- **FSM states and transitions:**
  - RELEASED (`level`=0):
    - `key_s`=1 -> PRESS_CHK, `dcnt`=0.
  - PRESS_CHK:
    - `key_s`=0 -> RELEASED.
    - Otherwise `dcnt`++.
    - `dcnt`==DB_CYCLES-1 with `key_s`=1 -> HELD: `level`<=1, `tick`<=1, `rcnt`=0.
  - HELD (`level`=1):
    - `key_s`=0 -> RELEASE_CHK, `dcnt`=0.
    - Otherwise `rcnt`++.
    - `rcnt`==REPEAT_DELAY-1 -> REPEAT: `tick`<=1, `rcnt`=0.
  - REPEAT (`level`=1, `repeating`=1):
    - `key_s`=0 -> RELEASE_CHK.
    - `rcnt`==REPEAT_RATE-1 -> `tick`<=1, `rcnt`=0.
    - Otherwise `rcnt`++.
  - RELEASE_CHK (`level`=1):
    - `key_s`=1 -> HELD, `rcnt`=0, no tick; the repeat delay restarts.
    - Otherwise `dcnt`++.
    - `dcnt`==DB_CYCLES-1 -> RELEASED: `level`<=0.
- **Tick rules:**
  - No tick on release.
  - At most one tick per cycle.
  - `tick` defaults to 0 every cycle.
- **Boundaries:**
  - `key` high during reset: after reset release, the FSM starts in RELEASED and needs a full debounce before the tick.
  - Glitch shorter than DB_CYCLES in either CHK state: aborted, no output change.

## Timing
- **Reset:** `rst`=0 forces the following immediately, with no clock edge needed:
  - `tick`=0, `level`=0, `repeating`=0.
  - Synchroniser FFs=0, counters=0, state=RELEASED.
- **Press latency:**
  - Edge 1 is the first rising edge with `key`=1, stable.
  - `tick` and `level` rise after edge DB_CYCLES+3.
  - `tick` is high for exactly one cycle.
- **Release latency:** `level` falls after edge DB_CYCLES+3, counted from the first edge with `key`=0.
- **Repeat timing:**
  - First repeat tick: REPEAT_DELAY edges after the first tick.
  - Then one tick every REPEAT_RATE edges.
- **`repeating`:** rises on the same edge as the first repeat tick.

## Configuration
- Macro: `STEP_AUTOREPEAT_EN`.
- **Defined:**
  - Auto-repeat is active as above.
  - `repeating` is driven by the FSM.
- **Undefined:**
  - The REPEAT state and `rcnt` are not built.
  - HELD ignores `rcnt`.
  - Exactly one tick per accepted press.
  - `repeating` is tied to 0.

## Test plan
All scenarios use DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.

1. **Reset:** `rst`=0 mid-cycle with `key`=1 -> `tick`/`level`/`repeating`=0 before the next clock edge. After `rst`=1 with `key` held, the first tick arrives 7 edges later.
2. **Clean press, held 30 edges, macro defined:**
   - `level`=1 and ticks after edges 7, 17, 20, 23, 26, 29.
   - `repeating`=1 from edge 17.
3. **Bounce:** `key` pattern 1,1,1,0 repeated 20 times -> `tick` never asserts, `level` stays 0.
4. **Release:**
   - After a press, drop `key` -> `level` falls after edge 7 of the release, no tick.
   - A 2-cycle low glitch while held -> `level` stays 1, no tick.
   - After that glitch the next repeat tick comes 10 edges after re-entry to HELD.
5. **Macro undefined, `key` held 50 edges:** exactly one tick at edge 7, `repeating`=0 throughout.
6. **Async reset mid-REPEAT:**
   - `rst`=0 between edges -> outputs 0 immediately.
   - After deassert with `key` held, the sequence restarts per scenario 2.
